// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: datapath width, instruction size and the
// fetch controller state encoding.
package rv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_ERR  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory request at a
// time, presents the returned word to decode and follows branch redirects.
//
// Build option: FETCH_CTRL_ALIGN_CHK_EN
//   defined   - a redirect to a non-word-aligned address parks the controller
//               in S_ERR (fetch_err_o=1, no requests) until reset.
//   undefined - the low redirect address bits are cleared and S_ERR is never
//               entered; fetch_err_o is tied low.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | just out of reset, outputs quiet, moves to S_REQ next cycle
// S_REQ  | imem_req_o high with imem_addr_o = pc, waiting for grant
// S_WAIT | request granted, waiting for rvalid (drop_q: discard that response)
// S_OUT  | instr_valid_o high, waiting for decode to take it (stall_i low)
// S_ERR  | misaligned redirect seen, stuck until reset
module fetch_ctrl
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            fetch_err_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] redir_pc;

`ifdef FETCH_CTRL_ALIGN_CHK_EN
  logic redir_bad;
  assign redir_pc    = redirect_pc_i;
  assign redir_bad   = redirect_i && ((redirect_pc_i & ALIGN_MASK) != '0);
  assign fetch_err_o = (state_q == S_ERR);
`else
  assign redir_pc    = redirect_pc_i & ~ALIGN_MASK;
  assign fetch_err_o = 1'b0;
`endif

  // The address bus is driven only while a request is being presented.
  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = imem_req_o ? pc_q : '0;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

  // Next-state and next-register computation; redirect wins over everything
  // except the error state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      S_IDLE: begin
        // No request is on the bus in IDLE, so a grant here carries no
        // meaning; only the redirect target is taken.
        if (redirect_i) pc_d = redir_pc;
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect_i) begin
          pc_d = redir_pc;
          if (imem_gnt_i) begin
            // The old address was accepted; swallow its response later.
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end else if (imem_gnt_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_i) begin
          pc_d = redir_pc;
          if (imem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d    = imem_rdata_i;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            state_d    = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (!stall_i) begin
          pc_d    = pc_q + PC_STEP;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        drop_d  = 1'b0;
      end
    endcase

`ifdef FETCH_CTRL_ALIGN_CHK_EN
    if (redir_bad && (state_q != S_ERR)) begin
      state_d = S_ERR;
      pc_d    = pc_q;
      drop_d  = 1'b0;
      valid_d = 1'b0;
    end
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC & ~ALIGN_MASK;
      drop_q     <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a per-cycle vector table for the basic
// fetch/stall sequence, hand-written redirect/wrap/reset sequences, then a
// randomized run against a transaction-level reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, redirect_i, imem_gnt_i, imem_rvalid_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, instr_valid_o, fetch_err_o;
  logic [31:0] imem_addr_o, instr_o, instr_pc_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
  } vec_t;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic rv, input logic [31:0] rdat);
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rdat;
  endtask

  function automatic vec_t mk(input logic st, input logic g, input logic rv,
                              input logic [31:0] rdat, input logic rq,
                              input logic [31:0] ad, input logic v,
                              input logic [31:0] ins, input logic [31:0] ipc);
    vec_t r;
    r.stall = st; r.gnt = g; r.rvalid = rv; r.rdata = rdat;
    r.req = rq; r.addr = ad; r.valid = v; r.instr = ins; r.ipc = ipc;
    return r;
  endfunction

  // Memory contents of the random phase: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_ipc", instr_pc_o, 0);
    chk("rst_err", fetch_err_o, 0);
    reset = 1'b0;
  endtask

  // Reference model state for the random phase.
  logic [31:0] exp_pc, o_addr, m_pc, rpc, st_addr;
  int          epoch, o_epoch, o_lat, delivered;
  bit          outst, mv, exp_new, chk_st, st, rd, g, rv;

  initial begin
    vec_t tbl[$];

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    //                st g  rv rdata          req addr   v  instr          ipc
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h00500093, 0, 32'h0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 1, 32'h00500093, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h4, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h00a00113, 0, 32'h0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 1, 32'h00a00113, 32'h4));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 1, 32'h00a00113, 32'h4));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 1, 32'h00a00113, 32'h4));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 1, 32'h00a00113, 32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 1, 32'h00a00113, 32'h4));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h8, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h00100193, 0, 32'h0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 1, 32'h00100193, 32'h8));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hc, 0, 32'h0,        32'h0));

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, 0, 0, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata);
      chk($sformatf("vec%0d_req", i), imem_req_o, tbl[i].req);
      chk($sformatf("vec%0d_addr", i), imem_addr_o, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), instr_valid_o, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("vec%0d_instr", i), instr_o, tbl[i].instr);
        chk($sformatf("vec%0d_ipc", i), instr_pc_o, tbl[i].ipc);
      end
      tick();
    end

    // Redirect while waiting: stale response dropped, refetch at 0x100.
    drive(0, 0, 0, 1, 0, 0);            tick();
    drive(0, 1, 32'h100, 0, 0, 0);      tick();
    chk("rdw_req_in_wait", imem_req_o, 0);
    drive(0, 0, 0, 0, 1, 32'hdeadbeef); tick();
    chk("rdw_stale_valid", instr_valid_o, 0);
    chk("rdw_req", imem_req_o, 1);
    chk("rdw_addr", imem_addr_o, 32'h100);
    drive(0, 0, 0, 1, 0, 0);            tick();
    drive(0, 0, 0, 0, 1, 32'h11111111); tick();
    chk("rdw_valid", instr_valid_o, 1);
    chk("rdw_ipc", instr_pc_o, 32'h100);
    chk("rdw_instr", instr_o, 32'h11111111);
    drive(0, 0, 0, 0, 0, 0);            tick();
    chk("rdw_next_addr", imem_addr_o, 32'h104);

    // Redirect coinciding with rvalid: that response is discarded.
    drive(0, 0, 0, 1, 0, 0);                    tick();
    drive(0, 1, 32'h200, 0, 1, 32'h22222222);   tick();
    chk("rdr_valid", instr_valid_o, 0);
    chk("rdr_addr", imem_addr_o, 32'h200);
    drive(0, 0, 0, 1, 0, 0);                    tick();
    drive(0, 0, 0, 0, 1, 32'h33333333);         tick();
    chk("rdr_ipc", instr_pc_o, 32'h200);
    chk("rdr_instr", instr_o, 32'h33333333);

    // Redirect in OUT beats stall.
    drive(1, 1, 32'h300, 0, 0, 0);              tick();
    chk("rdo_valid", instr_valid_o, 0);
    chk("rdo_addr", imem_addr_o, 32'h300);

    // Wrap from the top of the address space.
    drive(0, 1, 32'hffff_fffc, 0, 0, 0);        tick();
    chk("wrap_addr_top", imem_addr_o, 32'hffff_fffc);
    drive(0, 0, 0, 1, 0, 0);                    tick();
    drive(0, 0, 0, 0, 1, 32'h44444444);         tick();
    chk("wrap_ipc", instr_pc_o, 32'hffff_fffc);
    drive(0, 0, 0, 0, 0, 0);                    tick();
    chk("wrap_addr_zero", imem_addr_o, 32'h0);
    chk("wrap_req", imem_req_o, 1);

    // Misaligned redirect.
    drive(0, 1, 32'h102, 0, 0, 0);              tick();
`ifdef FETCH_CTRL_ALIGN_CHK_EN
    chk("mis_err", fetch_err_o, 1);
    chk("mis_req", imem_req_o, 0);
    chk("mis_valid", instr_valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h400, 1, 1, 32'h5);        tick();
      chk($sformatf("mis_err_hold%0d", i), fetch_err_o, 1);
      chk($sformatf("mis_req_hold%0d", i), imem_req_o, 0);
    end
`else
    chk("mis_err", fetch_err_o, 0);
    chk("mis_req", imem_req_o, 1);
    chk("mis_addr", imem_addr_o, 32'h100);
`endif

    // Reset while a request is outstanding; the late response is ignored.
    do_reset();
    tick();
    drive(0, 0, 0, 1, 0, 0);                    tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);                    tick();
    chk("rmid_req", imem_req_o, 0);
    chk("rmid_valid", instr_valid_o, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h55555555);         tick();
    chk("rmid_late_valid", instr_valid_o, 0);
    chk("rmid_req_after", imem_req_o, 1);
    drive(0, 0, 0, 0, 1, 32'h66666666);         tick();
    chk("rmid_late_valid2", instr_valid_o, 0);
    chk("rmid_addr", imem_addr_o, 32'h0);

    // Randomized run: the controller sits in REQ at address 0 here.
    exp_pc = 32'h0; epoch = 0; outst = 0; mv = 0; exp_new = 0;
    chk_st = 0; delivered = 0; m_pc = 0; o_addr = 0; o_epoch = 0; o_lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_valid", instr_valid_o, mv);
      if (mv) begin
        chk("rnd_pc", instr_pc_o, m_pc);
        chk("rnd_instr", instr_o, mem_word(m_pc));
      end
      if (exp_new) delivered++;
      if (chk_st) begin
        chk("rnd_req_hold", imem_req_o, 1);
        chk("rnd_addr_hold", imem_addr_o, st_addr);
      end
      if (outst && imem_req_o) chk("rnd_one_outstanding", imem_req_o, 0);
      chk("rnd_err", fetch_err_o, 0);

      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 15) == 0);
`ifdef FETCH_CTRL_ALIGN_CHK_EN
      rpc = $urandom & 32'h0000_fffc;
`else
      rpc = $urandom & 32'h0000_ffff;
`endif
      g  = imem_req_o && !outst && ($urandom_range(0, 1) == 1);
      rv = outst && (o_lat == 0) && ($urandom_range(0, 2) != 0);
      drive(st, rd, rpc, g, rv, rv ? mem_word(o_addr) : $urandom);

      exp_new = 0;
      if (rv) begin
        outst = 0;
        if (o_epoch == epoch && !rd) begin
          exp_new = 1;
          m_pc    = o_addr;
        end
      end else if (outst && o_lat > 0) begin
        o_lat--;
      end

      chk_st  = imem_req_o && !g && !rd;
      st_addr = exp_pc;
      if (g) begin
        chk("rnd_gnt_addr", imem_addr_o, exp_pc);
        outst   = 1;
        o_addr  = exp_pc;
        o_epoch = epoch;
        o_lat   = $urandom_range(0, 2);
      end

      if (mv) begin
        if (rd) mv = 0;
        else if (!st) begin
          mv     = 0;
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (exp_new) mv = 1;

      if (rd) begin
        epoch++;
        exp_pc = rpc & ~32'h3;
      end
      tick();
    end
    chk("rnd_liveness", (delivered > 50) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset (word-aligned).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 stall_i  input  1  SHALL mean the decode stage cannot accept an instruction this cycle.
REQ-005 redirect_i  input  1  SHALL mean a taken branch or jump; load redirect_pc_i.
REQ-006 redirect_pc_i  input  32  SHALL be the new fetch address, sampled when redirect_i=1.
REQ-007 imem_req_o  output  1  SHALL be the instruction-memory request strobe.
REQ-008 imem_addr_o  output  32  SHALL be the fetch address; stable while imem_req_o=1.
REQ-009 imem_gnt_i  input  1  SHALL mean the memory accepted the request this cycle.
REQ-010 imem_rvalid_i  input  1  SHALL mean imem_rdata_i is valid; at least 1 cycle after grant.
REQ-011 imem_rdata_i  input  32  SHALL be the returned instruction word.
REQ-012 instr_valid_o  output  1  SHALL mean instr_o and instr_pc_o hold a fetched instruction.
REQ-013 instr_o  output  32  SHALL be the fetched instruction.
REQ-014 instr_pc_o  output  32  SHALL be the address instr_o was fetched from.
REQ-015 fetch_err_o  output  1  SHALL flag a misaligned redirect (see Configuration).

Function
REQ-016 Controller SHALL be a registered FSM with states IDLE, REQ, WAIT, OUT, ERR; at most one outstanding memory request.
REQ-017 IDLE: outputs quiet; SHALL go to REQ unconditionally next cycle.
REQ-018 REQ: imem_req_o=1, imem_addr_o=pc; on imem_gnt_i SHALL go to WAIT, else stay in REQ with the same address.
REQ-019 WAIT: on imem_rvalid_i SHALL register instr_o<=imem_rdata_i, instr_pc_o<=pc, set instr_valid_o=1 next cycle, go to OUT.
REQ-020 OUT: if stall_i=0 the instruction is consumed; SHALL set pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0) and go to REQ; if stall_i=1 SHALL hold instr_o, instr_pc_o, instr_valid_o unchanged.
REQ-021 Fetch-to-valid latency SHALL be 1 cycle after imem_rvalid_i; back-to-back memory (gnt in REQ, rvalid next cycle) yields one instruction per 3 cycles.
REQ-022 redirect_i SHALL take priority over stall_i and over consumption in every state except ERR.
REQ-023 Redirect in IDLE or REQ: pc<=redirect_pc_i, state REQ; if imem_gnt_i in that same cycle, SHALL go to WAIT with drop flag set.
REQ-024 Redirect in WAIT: pc<=redirect_pc_i, drop flag set; if imem_rvalid_i in the same cycle, that response SHALL be discarded and state go to REQ.
REQ-025 Drop flag set in WAIT: next imem_rvalid_i SHALL be discarded (no instr_valid_o), flag cleared, state to REQ.
REQ-026 Redirect in OUT: instr_valid_o SHALL deassert next cycle, pc<=redirect_pc_i, state to REQ.
REQ-027 imem_rvalid_i outside WAIT SHALL be ignored.

Reset
REQ-028 On reset=1 at a clock edge: state IDLE, pc<=RESET_PC, drop flag 0, imem_req_o=0, imem_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, fetch_err_o=0.
REQ-029 Reset mid-transaction SHALL abandon any outstanding request; a later imem_rvalid_i SHALL be ignored (not in WAIT).

Configuration
REQ-030 Macro FETCH_CTRL_ALIGN_CHK_EN defined: redirect with redirect_pc_i[1:0]!=0 SHALL go to ERR; fetch_err_o=1, imem_req_o=0, instr_valid_o=0; ERR exits only on reset.
REQ-031 Macro undefined: redirect_pc_i[1:0] SHALL be forced to 2'b00, ERR unreachable, fetch_err_o tied 0.

Structure
REQ-032 Shared package rv_pkg SHALL hold the fetch_state_e enum, XLEN=32, and INSTR_BYTES=4.
REQ-033 No sub-module; single module with one next-state block and one registered block.

Verification
REQ-034 Reset, RESET_PC=0, gnt same cycle, rvalid 1 cycle later, rdata=32'h00500093, no stall -> addresses 0,4,8 requested; instr_valid_o with instr_pc_o=0, instr_o=32'h00500093.
REQ-035 gnt withheld 3 cycles -> imem_req_o held 1, imem_addr_o stable at 32'h4 throughout.
REQ-036 stall_i=1 for 4 cycles in OUT -> instr_o, instr_pc_o, instr_valid_o unchanged, no new request; release -> next request at pc+4.
REQ-037 redirect_i with redirect_pc_i=32'h100 while in WAIT -> next rvalid discarded, next request addr 32'h100, no instr_valid_o for old pc.
REQ-038 redirect_pc_i=32'h102 with FETCH_CTRL_ALIGN_CHK_EN -> fetch_err_o=1, imem_req_o=0 until reset; without macro -> request at 32'h100.
REQ-039 pc=32'hFFFF_FFFC consumed -> next request at 32'h0000_0000.
